fir_seq_mac: RTL and testbench
==============================

Name: fir_seq_mac

Overview:
Consumer end of the low-frequency sample queue. Watches the queue's sequencing burst and drives the coefficient ROM address in lockstep with it. Multiply-accumulates left and right samples against the coefficients and emits one filtered, saturated stereo sample per burst. Sits between the queue/ROM pair and the band-equalizer summing stage.

Parameters:
TAPS, 1021, expected burst length in cycles; also the number of coefficients.
CA_W, 10, coefficient address width.
ACC_W, 42, accumulator width (32 + ceil(log2(TAPS))).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous, active-low reset.
sequencing  in  1  queue burst strobe; lft_in/rght_in valid in every cycle it is high.
lft_in  in  16  signed left sample from the queue.
rght_in  in  16  signed right sample from the queue.
coeff_addr  out  CA_W  coefficient ROM read address.
coeff  in  16  signed Q1.15 coefficient; registered ROM, valid one cycle after coeff_addr.
lft_filt  out  16  signed filtered left result.
rght_filt  out  16  signed filtered right result.
filt_vld  out  1  one-cycle pulse when lft_filt/rght_filt update.
len_err  out  1  one-cycle pulse when a burst length is not TAPS.

Behaviour:
- Reset (async): all outputs 0, accumulators 0, tap counter 0, state IDLE. Reset mid-burst aborts the burst: no filt_vld, no len_err, and the remainder of that burst is ignored until sequencing is low.
- coeff_addr: registered tap counter.
  - 0 in IDLE.
  - While sequencing=1, coeff_addr in cycle k equals k (k = 0..). It increments every cycle sequencing is high.
  - Saturates at TAPS-1; it never wraps.
- Alignment: lft_in, rght_in and sequencing are registered once (smpl_d, seq_d). In each cycle with seq_d=1, compute prod = smpl_d * coeff as a signed 16x16 -> 32-bit product, sign-extend it to ACC_W and add it to the accumulator. This applies to left and right independently, with the same coeff.
- States:
  - IDLE: sequencing rise -> MAC. Clear both accumulators and the tap count on entry.
  - MAC: accumulate while seq_d=1; count products. On seq_d falling -> DONE.
  - DONE (1 cycle):
    - If count == TAPS: lft_filt = sat16(acc_l >>> 15), rght_filt = sat16(acc_r >>> 15), filt_vld=1.
    - Otherwise: len_err=1, outputs hold, filt_vld=0.
    - Then go to IDLE.
- Output rules:
  - Arithmetic shift gives floor rounding.
  - sat16 clamps to 0x7FFF / 0x8000.
  - lft_filt/rght_filt hold their value between pulses.
- Latency: filt_vld asserts 2 cycles after the last cycle of sequencing=1.
- Back-to-back bursts:
  - A new sequencing rise during DONE is legal. The accumulator clear for the new burst takes priority after the DONE result is captured.
  - One idle cycle between bursts is sufficient.
- Overlong burst: products beyond TAPS are still accumulated using coeff at address TAPS-1 (the address saturates). The count exceeds TAPS, so len_err fires and filt_vld does not.
- Bursts shorter than TAPS, including a 1-cycle burst: len_err, no filt_vld.

Test Plan:
- Impulse: coeff[0]=0x7FFF, all others 0; burst of 1021 with first sample L=0x1234, R=0xEDCC and all others 0 -> filt_vld once, lft_filt=0x1233, rght_filt=0xEDCC (floor of -0x1234*0x7FFF/2^15 = -0x1234).
- Positive saturation: all coeff=0x4000, all samples 0x1000 -> lft_filt=rght_filt=0x7FFF. Negative saturation: all coeff=0x7FFF, samples 0x8000 -> 0x8000.
- Address tracking: during a 1021-cycle burst, coeff_addr steps 0..1020 exactly in step with sequencing, then returns to 0. filt_vld asserts exactly 2 cycles after sequencing falls.
- Length error: burst of 500 cycles -> len_err pulse, no filt_vld, prior lft_filt value unchanged. Burst of 1030 cycles -> same result.
- Reset mid-burst: assert rst_n low at tap 300 -> all outputs 0 immediately. Next full burst yields the correct result with no stale accumulation.
- Back-to-back: two 1021-cycle bursts with 1 idle cycle, the first with impulse data and the second with all zeros -> two filt_vld pulses, results 0x1233 then 0x0000.

Source files
------------

// File: rtl/fir_seq_mac.sv
// Sequential stereo FIR MAC: follows the sample-queue burst, drives the coefficient ROM address
// in lockstep, and emits one saturated Q1.15-scaled stereo result per burst of exactly TAPS samples.
//
// state | meaning
// IDLE  | waiting for an accepted burst start; coeff_addr held at 0
// MAC   | accumulating one product pair per registered burst cycle
// DONE  | result (or len_err) presented for one cycle; a new burst may start here
module fir_seq_mac #(
    parameter int TAPS  = 1021,
    parameter int CA_W  = 10,
    parameter int ACC_W = 42
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sequencing,
    input  logic [15:0]     lft_in,
    input  logic [15:0]     rght_in,
    output logic [CA_W-1:0] coeff_addr,
    input  logic [15:0]     coeff,
    output logic [15:0]     lft_filt,
    output logic [15:0]     rght_filt,
    output logic            filt_vld,
    output logic            len_err
);

    localparam int CNT_W = $clog2(TAPS + 1) + 1;
    localparam logic [CA_W-1:0]         ADDR_MAX = CA_W'(TAPS - 1);
    localparam logic [CNT_W-1:0]        CNT_TAPS = CNT_W'(TAPS);
    localparam logic signed [ACC_W-1:0] POS_MAX  = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] NEG_MIN  = -(ACC_W'(32768));

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t state, state_nxt;

    logic                     armed;
    logic                     acpt;
    logic                     seq_d;
    logic signed [15:0]       lft_d, rght_d;
    logic signed [31:0]       prod_l, prod_r;
    logic signed [ACC_W-1:0]  acc_l, acc_r, acc_l_nxt, acc_r_nxt;
    logic [CNT_W-1:0]         cnt, cnt_inc;
    logic                     clr, acc_en, finish, len_ok;

    function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> 15;
        if (s > POS_MAX)
            return 16'h7FFF;
        else if (s < NEG_MIN)
            return 16'h8000;
        else
            return s[15:0];
    endfunction

    // A burst already in flight when reset releases is ignored until sequencing drops.
    assign acpt = sequencing & armed;

    assign prod_l    = lft_d * $signed(coeff);
    assign prod_r    = rght_d * $signed(coeff);
    assign acc_l_nxt = acc_l + {{(ACC_W-32){prod_l[31]}}, prod_l};
    assign acc_r_nxt = acc_r + {{(ACC_W-32){prod_r[31]}}, prod_r};
    assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
    assign len_ok    = (cnt_inc == CNT_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        acc_en    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (acpt) begin
                    state_nxt = MAC;
                    clr       = 1'b1;
                end
            end
            MAC: begin
                acc_en = seq_d;
                // seq_d drops next cycle: fold the final product straight into the result
                if (!acpt) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                end
            end
            DONE: begin
                if (acpt) begin
                    state_nxt = MAC;
                    clr       = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed      <= 1'b0;
            seq_d      <= 1'b0;
            lft_d      <= '0;
            rght_d     <= '0;
            coeff_addr <= '0;
            acc_l      <= '0;
            acc_r      <= '0;
            cnt        <= '0;
            lft_filt   <= '0;
            rght_filt  <= '0;
            filt_vld   <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            armed  <= armed | ~sequencing;
            seq_d  <= acpt;
            lft_d  <= lft_in;
            rght_d <= rght_in;

            if (!acpt)
                coeff_addr <= '0;
            else if (coeff_addr != ADDR_MAX)
                coeff_addr <= coeff_addr + 1'b1;

            if (clr) begin
                acc_l <= '0;
                acc_r <= '0;
                cnt   <= '0;
            end else if (acc_en) begin
                acc_l <= acc_l_nxt;
                acc_r <= acc_r_nxt;
                cnt   <= cnt_inc;
            end

            filt_vld <= finish & len_ok;
            len_err  <= finish & ~len_ok;
            if (finish && len_ok) begin
                lft_filt  <= sat16(acc_l_nxt);
                rght_filt <= sat16(acc_r_nxt);
            end
        end
    end

endmodule

// File: tb/tb_fir_seq_mac.sv
// Directed bench for fir_seq_mac: registered ROM model, burst driver, and pulse logger with
// hand-computed expected results.
module tb_fir_seq_mac;

    localparam int TAPS = 1021;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sequencing = 1'b0;
    logic [15:0] lft_in = '0;
    logic [15:0] rght_in = '0;
    logic [9:0]  coeff_addr;
    logic [15:0] coeff = '0;
    logic [15:0] lft_filt, rght_filt;
    logic        filt_vld, len_err;

    fir_seq_mac #(.TAPS(TAPS), .CA_W(10), .ACC_W(42)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sequencing (sequencing),
        .lft_in     (lft_in),
        .rght_in    (rght_in),
        .coeff_addr (coeff_addr),
        .coeff      (coeff),
        .lft_filt   (lft_filt),
        .rght_filt  (rght_filt),
        .filt_vld   (filt_vld),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [0:1023];
    always @(posedge clk) coeff <= rom[coeff_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          vld_n = 0;
    int          err_n = 0;
    int          vld_cyc = 0;
    logic [15:0] log_l [32];
    logic [15:0] log_r [32];
    always @(negedge clk) begin
        if (filt_vld) begin
            if (vld_n < 32) begin
                log_l[vld_n] = lft_filt;
                log_r[vld_n] = rght_filt;
            end
            vld_n++;
            vld_cyc = cyc;
        end
        if (len_err) err_n++;
    end

    int total = 0;
    int bad = 0;
    int addr_bad = 0;
    int last_hi = 0;
    int v0, e0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic set_rom(input int mode);
        for (int i = 0; i < 1024; i++) begin
            case (mode)
                0:       rom[i] = (i == 0) ? 16'h7FFF : 16'h0000;
                1:       rom[i] = 16'h4000;
                2:       rom[i] = 16'h7FFF;
                default: rom[i] = 16'h0000;
            endcase
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered and left at posedge+1; cycle k of the burst is the interval after the k-th drive.
    task automatic burst(input int len, input int mode, input int rst_at);
        int exp_addr;
        for (int k = 0; k < len; k++) begin
            sequencing = 1'b1;
            case (mode)
                0: begin
                    lft_in  = (k == 0) ? 16'h1234 : 16'h0000;
                    rght_in = (k == 0) ? 16'hEDCC : 16'h0000;
                end
                1: begin lft_in = 16'h1000; rght_in = 16'h1000; end
                2: begin lft_in = 16'h8000; rght_in = 16'h8000; end
                default: begin lft_in = 16'h0000; rght_in = 16'h0000; end
            endcase
            last_hi = cyc;
            if (rst_at >= 0 && k > rst_at) exp_addr = 0;
            else exp_addr = (k < TAPS - 1) ? k : TAPS - 1;
            @(negedge clk);
            if (int'(coeff_addr) != exp_addr) addr_bad++;
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_addr", 32'(coeff_addr), 32'd0);
                chk("rst_lft", 32'(lft_filt), 32'd0);
                chk("rst_rght", 32'(rght_filt), 32'd0);
                chk("rst_vld", 32'(filt_vld), 32'd0);
                chk("rst_err", 32'(len_err), 32'd0);
                #1;
                rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        sequencing = 1'b0;
        lft_in     = '0;
        rght_in    = '0;
    endtask

    initial begin
        set_rom(3);
        idle(3);
        chk("reset_addr", 32'(coeff_addr), 32'd0);
        chk("reset_lft", 32'(lft_filt), 32'd0);
        chk("reset_rght", 32'(rght_filt), 32'd0);
        chk("reset_vld", 32'(filt_vld), 32'd0);
        chk("reset_err", 32'(len_err), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // impulse, address tracking and latency
        set_rom(0);
        v0 = vld_n; e0 = err_n; addr_bad = 0;
        burst(TAPS, 0, -1);
        idle(5);
        chk("imp_vld_cnt", 32'(vld_n - v0), 32'd1);
        chk("imp_err_cnt", 32'(err_n - e0), 32'd0);
        chk("imp_lft", 32'(lft_filt), 32'h1233);
        chk("imp_rght", 32'(rght_filt), 32'hEDCC);
        chk("imp_latency", 32'(vld_cyc - last_hi), 32'd2);
        chk("imp_addr_track", 32'(addr_bad), 32'd0);
        chk("imp_addr_idle", 32'(coeff_addr), 32'd0);

        // positive saturation
        set_rom(1);
        v0 = vld_n;
        burst(TAPS, 1, -1);
        idle(5);
        chk("psat_vld_cnt", 32'(vld_n - v0), 32'd1);
        chk("psat_lft", 32'(lft_filt), 32'h7FFF);
        chk("psat_rght", 32'(rght_filt), 32'h7FFF);

        // negative saturation
        set_rom(2);
        v0 = vld_n;
        burst(TAPS, 2, -1);
        idle(5);
        chk("nsat_vld_cnt", 32'(vld_n - v0), 32'd1);
        chk("nsat_lft", 32'(lft_filt), 32'h8000);
        chk("nsat_rght", 32'(rght_filt), 32'h8000);

        // short burst
        v0 = vld_n; e0 = err_n; addr_bad = 0;
        burst(500, 1, -1);
        idle(5);
        chk("short_err_cnt", 32'(err_n - e0), 32'd1);
        chk("short_vld_cnt", 32'(vld_n - v0), 32'd0);
        chk("short_lft_hold", 32'(lft_filt), 32'h8000);

        // overlong burst: address saturates at TAPS-1
        v0 = vld_n; e0 = err_n;
        burst(1030, 1, -1);
        idle(5);
        chk("long_err_cnt", 32'(err_n - e0), 32'd1);
        chk("long_vld_cnt", 32'(vld_n - v0), 32'd0);
        chk("long_lft_hold", 32'(lft_filt), 32'h8000);
        chk("len_addr_track", 32'(addr_bad), 32'd0);
        chk("long_addr_idle", 32'(coeff_addr), 32'd0);

        // single-cycle burst
        e0 = err_n; v0 = vld_n;
        burst(1, 1, -1);
        idle(5);
        chk("one_err_cnt", 32'(err_n - e0), 32'd1);
        chk("one_vld_cnt", 32'(vld_n - v0), 32'd0);

        // reset at tap 300, remainder ignored, then clean full burst
        set_rom(0);
        v0 = vld_n; e0 = err_n; addr_bad = 0;
        burst(TAPS, 0, 300);
        idle(5);
        chk("rstb_vld_cnt", 32'(vld_n - v0), 32'd0);
        chk("rstb_err_cnt", 32'(err_n - e0), 32'd0);
        chk("rstb_addr_track", 32'(addr_bad), 32'd0);
        v0 = vld_n;
        burst(TAPS, 0, -1);
        idle(5);
        chk("post_rst_vld_cnt", 32'(vld_n - v0), 32'd1);
        chk("post_rst_lft", 32'(lft_filt), 32'h1233);
        chk("post_rst_rght", 32'(rght_filt), 32'hEDCC);

        // back-to-back with one idle cycle
        v0 = vld_n; e0 = err_n; addr_bad = 0;
        burst(TAPS, 0, -1);
        idle(1);
        burst(TAPS, 3, -1);
        idle(5);
        chk("b2b_vld_cnt", 32'(vld_n - v0), 32'd2);
        chk("b2b_err_cnt", 32'(err_n - e0), 32'd0);
        chk("b2b_addr_track", 32'(addr_bad), 32'd0);
        if (v0 + 1 < 32) begin
            chk("b2b_lft0", 32'(log_l[v0]), 32'h1233);
            chk("b2b_rght0", 32'(log_r[v0]), 32'hEDCC);
            chk("b2b_lft1", 32'(log_l[v0+1]), 32'h0000);
            chk("b2b_rght1", 32'(log_r[v0+1]), 32'h0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
